// File: rtl/sprite_draw_scheduler_pkg.sv
// Shared graphics constants for the frogger display path: screen geometry,
// colour encoding and the sprite scheduler FSM states.
package frogger_gfx_pkg;

  localparam int SCREEN_X = 160;
  localparam int SCREEN_Y = 120;
  localparam int SCR_X_W  = 8;
  localparam int SCR_Y_W  = 7;
  localparam int COLOR_W  = 3;

  localparam logic [COLOR_W-1:0] TRANSPARENT = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    ACK   = 2'd3
  } state_t;

endpackage

// File: rtl/sprite_draw_scheduler_if.sv
// Requester / sprite-ROM / VGA-port bundle of the sprite draw scheduler.
interface sprite_draw_scheduler_if #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH_SX = 4,
  parameter int WIDTH_SY = 3
) ();
  import frogger_gfx_pkg::*;

  // Handshake: a requester holds req[i] high as a level; the scheduler samples
  // req only while idle, and answers with a one-cycle ack[i] once the whole
  // sprite has been written. color_in must be the ROM word for the sx/sy that
  // were presented one cycle earlier. vga_plot is a single-cycle write strobe.
  logic [NUM_REQ-1:0]         req;
  logic [8*NUM_REQ-1:0]       org_x;
  logic [7*NUM_REQ-1:0]       org_y;
  logic [NUM_REQ-1:0]         ack;
  logic                       busy;
  logic [2:0]                 sel;
  logic [WIDTH_SX-1:0]        sx;
  logic [WIDTH_SY-1:0]        sy;
  logic [COLOR_W-1:0]         color_in;
  logic [SCR_X_W-1:0]         vga_x;
  logic [SCR_Y_W-1:0]         vga_y;
  logic [COLOR_W-1:0]         vga_color;
  logic                       vga_plot;
  state_t                     dbg_state;

  modport master (
    output req, org_x, org_y, color_in,
    input  ack, busy, sel, sx, sy, vga_x, vga_y, vga_color, vga_plot, dbg_state
  );

  modport slave (
    input  req, org_x, org_y, color_in,
    output ack, busy, sel, sx, sy, vga_x, vga_y, vga_color, vga_plot, dbg_state
  );

endinterface

// File: rtl/sprite_draw_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [2:0]         i_ptr,
  output logic [2:0]         o_grant_idx,
  output logic               o_grant_valid
);

  logic [2:0] w_idx;

  // Walk from the farthest candidate back to i_ptr so the closest one wins.
  always_comb begin
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_idx         = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = 3'((int'(i_ptr) + k) % NUM_REQ);
      if (i_req[w_idx]) begin
        o_grant_idx   = w_idx;
        o_grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Shares one sprite-ROM read path and one VGA write port among NUM_REQ
// requesters: scans a sprite, clips/filters each pixel, then acks the owner.
module sprite_draw_scheduler #(
  parameter int          NUM_REQ     = 4,
  parameter int          SPRITE_W    = 10,
  parameter int          SPRITE_H    = 6,
  parameter int          WIDTH_SX    = 4,
  parameter int          WIDTH_SY    = 3,
  parameter int          SCREEN_X    = frogger_gfx_pkg::SCREEN_X,
  parameter int          SCREEN_Y    = frogger_gfx_pkg::SCREEN_Y,
  parameter logic [2:0]  TRANSPARENT = frogger_gfx_pkg::TRANSPARENT
) (
  input  logic                   clk,
  input  logic                   reset,
  sprite_draw_scheduler_if.slave bus
);
  import frogger_gfx_pkg::*;

  state_t              r_state, w_next;
  logic [2:0]          r_sel, r_ptr;
  logic [7:0]          r_org_x;
  logic [6:0]          r_org_y;
  logic [WIDTH_SX-1:0] r_sx;
  logic [WIDTH_SY-1:0] r_sy;

  logic                r_stg_valid;
  logic [WIDTH_SX-1:0] r_stg_sx;
  logic [WIDTH_SY-1:0] r_stg_sy;
  logic [7:0]          r_stg_ox;
  logic [6:0]          r_stg_oy;

  logic [2:0]          w_grant_idx;
  logic                w_grant_valid;
  logic                w_do_grant, w_scan, w_in_ack;
  logic                w_sx_wrap, w_last_addr;
  logic [8:0]          w_sum_x;
  logic [7:0]          w_sum_y;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req        (bus.req),
    .i_ptr        (r_ptr),
    .o_grant_idx  (w_grant_idx),
    .o_grant_valid(w_grant_valid)
  );

  assign w_sx_wrap   = (r_sx == WIDTH_SX'(SPRITE_W - 1));
  assign w_last_addr = w_sx_wrap && (r_sy == WIDTH_SY'(SPRITE_H - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_do_grant = 1'b0;
    w_scan     = 1'b0;
    w_in_ack   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid && !reset) begin
          w_do_grant = 1'b1;
          w_next     = SCAN;
        end
      end
      SCAN: begin
        w_scan = 1'b1;
        if (w_last_addr) w_next = FLUSH;
      end
      FLUSH:   w_next = ACK;
      ACK: begin
        w_in_ack = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel       <= '0;
      r_ptr       <= '0;
      r_org_x     <= '0;
      r_org_y     <= '0;
      r_sx        <= '0;
      r_sy        <= '0;
      r_stg_valid <= 1'b0;
      r_stg_sx    <= '0;
      r_stg_sy    <= '0;
      r_stg_ox    <= '0;
      r_stg_oy    <= '0;
    end else begin
      if (w_do_grant) begin
        r_sel   <= w_grant_idx;
        r_org_x <= bus.org_x[int'(w_grant_idx)*8 +: 8];
        r_org_y <= bus.org_y[int'(w_grant_idx)*7 +: 7];
        r_sx    <= '0;
        r_sy    <= '0;
      end else if (w_scan) begin
        if (w_sx_wrap) begin
          r_sx <= '0;
          r_sy <= w_last_addr ? '0 : r_sy + 1'b1;
        end else begin
          r_sx <= r_sx + 1'b1;
        end
      end
      if (w_in_ack) r_ptr <= (r_sel == 3'(NUM_REQ - 1)) ? 3'd0 : r_sel + 3'd1;
      // Stage is aligned with color_in, which answers last cycle's address.
      r_stg_valid <= w_scan;
      r_stg_sx    <= r_sx;
      r_stg_sy    <= r_sy;
      r_stg_ox    <= r_org_x;
      r_stg_oy    <= r_org_y;
    end
  end

  // Sums keep one extra bit so sprites hanging off the right/bottom clip
  // instead of wrapping back onto the screen.
  assign w_sum_x = {1'b0, r_stg_ox} + 9'(r_stg_sx);
  assign w_sum_y = {1'b0, r_stg_oy} + 8'(r_stg_sy);

  assign bus.vga_x     = w_sum_x[7:0];
  assign bus.vga_y     = w_sum_y[6:0];
  assign bus.vga_color = r_stg_valid ? bus.color_in : '0;
  assign bus.vga_plot  = r_stg_valid && (w_sum_x < 9'(SCREEN_X)) &&
                         (w_sum_y < 8'(SCREEN_Y)) && (bus.color_in != TRANSPARENT);

  assign bus.ack       = w_in_ack ? (NUM_REQ'(1) << r_sel) : '0;
  assign bus.busy      = (r_state == SCAN) || (r_state == FLUSH) || w_do_grant;
  assign bus.sel       = r_sel;
  assign bus.sx        = r_sx;
  assign bus.sy        = r_sy;
  assign bus.dbg_state = r_state;

endmodule
